// File: rtl/engine_inv_round_transformer.sv
// engine_inv_round_transformer: iterative AES-128 inverse cipher, one round per clock.
// Optional `INV_SBOX_PIPE_EN registers the InvSubBytes output, making each round two clocks.

module engine_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 maps to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] sq;
    p  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

  logic [7:0] w_aff;
  assign w_aff  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                  {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
  assign o_byte = gf_inv(w_aff);
endmodule

module engine_inv_round_transformer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [127:0] ciphertext,
  input  logic         transformer_start,
  input  logic         output_read,
  input  logic [127:0] round0_key,
  input  logic [127:0] round1_key,
  input  logic [127:0] round2_key,
  input  logic [127:0] round3_key,
  input  logic [127:0] round4_key,
  input  logic [127:0] round5_key,
  input  logic [127:0] round6_key,
  input  logic [127:0] round7_key,
  input  logic [127:0] round8_key,
  input  logic [127:0] round9_key,
  input  logic [127:0] round10_key,
  output logic [127:0] plaintext,
  output logic         transformer_done,
  output logic         transformer_busy
);
  localparam int NUM_LANES = 16;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_plaintext;
  logic [3:0]   r_round;
  logic         r_start_q, r_done, r_busy;
  logic         w_start_edge, w_step;
  logic [127:0] w_sb, w_sb_use, w_rkey, w_ark, w_mix;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  assign w_start_edge = transformer_start & ~r_start_q;

  // Byte k = col*4+row sits at [127-8k]; InvShiftRows folds into the S-box input select.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int COL = g / 4;
    localparam int ROW = g % 4;
    localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
    engine_inv_sbox u_sbox (
      .i_byte(r_state[127-8*SRC -: 8]),
      .o_byte(w_sb[127-8*g -: 8])
    );
  end

`ifdef INV_SBOX_PIPE_EN
  logic [127:0] r_sb_q;
  logic         r_phase;
  assign w_sb_use = r_sb_q;
  assign w_step   = r_phase;
`else
  assign w_sb_use = w_sb;
  assign w_step   = 1'b1;
`endif

  always_comb begin
    w_rkey = '0;
    case (r_round)
      4'd1:    w_rkey = round1_key;
      4'd2:    w_rkey = round2_key;
      4'd3:    w_rkey = round3_key;
      4'd4:    w_rkey = round4_key;
      4'd5:    w_rkey = round5_key;
      4'd6:    w_rkey = round6_key;
      4'd7:    w_rkey = round7_key;
      4'd8:    w_rkey = round8_key;
      4'd9:    w_rkey = round9_key;
      default: w_rkey = '0;
    endcase
  end

  assign w_ark = w_sb_use ^ w_rkey;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[127-32*c -: 8];
    assign w_a1 = w_ark[119-32*c -: 8];
    assign w_a2 = w_ark[111-32*c -: 8];
    assign w_a3 = w_ark[103-32*c -: 8];
    assign w_mix[127-32*c -: 8] = me(w_a0) ^ mb(w_a1) ^ md(w_a2) ^ m9(w_a3);
    assign w_mix[119-32*c -: 8] = m9(w_a0) ^ me(w_a1) ^ mb(w_a2) ^ md(w_a3);
    assign w_mix[111-32*c -: 8] = md(w_a0) ^ m9(w_a1) ^ me(w_a2) ^ mb(w_a3);
    assign w_mix[103-32*c -: 8] = mb(w_a0) ^ md(w_a1) ^ m9(w_a2) ^ me(w_a3);
  end

  always_ff @(posedge clk) begin
    if (rst_) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (w_start_edge) w_fsm_nxt = S_ROUND;
      S_ROUND: if (w_step && r_round == 4'd1) w_fsm_nxt = S_FINAL;
      S_FINAL: if (w_step) w_fsm_nxt = S_DONE;
      S_DONE:  if (output_read) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state     <= '0;
      r_plaintext <= '0;
      r_round     <= '0;
      r_start_q   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef INV_SBOX_PIPE_EN
      r_sb_q      <= '0;
      r_phase     <= 1'b0;
`endif
    end else begin
      r_start_q <= transformer_start;
`ifdef INV_SBOX_PIPE_EN
      if ((r_fsm == S_ROUND || r_fsm == S_FINAL) && !r_phase) r_sb_q <= w_sb;
      if (r_fsm == S_ROUND || r_fsm == S_FINAL) r_phase <= ~r_phase;
      else                                      r_phase <= 1'b0;
`endif
      case (r_fsm)
        S_IDLE: if (w_start_edge) begin
          r_state <= ciphertext ^ round10_key;
          r_round <= 4'(NR - 1);
          r_busy  <= 1'b1;
        end
        S_ROUND: if (w_step) begin
          r_state <= w_mix;
          r_round <= r_round - 4'd1;
        end
        S_FINAL: if (w_step) begin
          r_plaintext <= w_sb_use ^ round0_key;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        S_DONE: if (output_read) r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign plaintext        = r_plaintext;
  assign transformer_done = r_done;
  assign transformer_busy = r_busy;
endmodule

// File: tb/tb_engine_inv_round_transformer.sv
// Randomized bench for engine_inv_round_transformer: a byte-level AES encryption model
// produces ciphertexts whose plaintext is known; the DUT must recover it.

module tb_engine_inv_round_transformer;
`ifdef INV_SBOX_PIPE_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 10;
`endif

  logic         clk, rst_, transformer_start, output_read;
  logic [127:0] ciphertext, plaintext;
  logic         transformer_done, transformer_busy;
  logic [127:0] rk_a [0:10];
  logic [7:0]   sbox_t [0:255];
  int           n_chk, n_err;

  engine_inv_round_transformer dut (
    .clk(clk), .rst_(rst_), .ciphertext(ciphertext),
    .transformer_start(transformer_start), .output_read(output_read),
    .round0_key(rk_a[0]), .round1_key(rk_a[1]), .round2_key(rk_a[2]),
    .round3_key(rk_a[3]), .round4_key(rk_a[4]), .round5_key(rk_a[5]),
    .round6_key(rk_a[6]), .round7_key(rk_a[7]), .round8_key(rk_a[8]),
    .round9_key(rk_a[9]), .round10_key(rk_a[10]),
    .plaintext(plaintext), .transformer_done(transformer_done),
    .transformer_busy(transformer_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference AES model (encryption side) ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input bit mix);
    logic [127:0] t, o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(c*4+r) -: 8] = sbox_t[gb(s, ((c + r) % 4) * 4 + r)];
    o = t;
    if (mix)
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = gb(t, c*4); a1 = gb(t, c*4+1); a2 = gb(t, c*4+2); a3 = gb(t, c*4+3);
        o[127-32*c -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
        o[103-32*c -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
      end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_a[0];
    for (int r = 1; r < 10; r++) s = enc_round(s, 1'b1) ^ rk_a[r];
    return enc_round(s, 1'b0) ^ rk_a[10];
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---- operations ----
  task automatic run_op(input logic [127:0] ct, input logic [127:0] exp_pt, input bit spur);
    int cnt;
    ciphertext = ct;
    transformer_start = 1'b1;
    step();
    cnt = 1;
    chk("busy_on", transformer_busy, 1);
    ciphertext = ~ct;
    if (spur) begin
      transformer_start = 1'b0;
      step(); cnt++;
      transformer_start = 1'b1;
      output_read = 1'b1;
      step(); cnt++;
      output_read = 1'b0;
    end
    while (!transformer_done && cnt < 200) begin
      step(); cnt++;
    end
    chk("latency", cnt, LAT + 1);
    chk("busy_off", transformer_busy, 0);
    chk("pt", plaintext, exp_pt);
  endtask

  task automatic release_out(input logic [127:0] exp_pt);
    transformer_start = 1'b0;
    output_read = 1'b1;
    step();
    output_read = 1'b0;
    chk("done_clr", transformer_done, 0);
    chk("pt_keep", plaintext, exp_pt);
  endtask

  localparam logic [127:0] FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FCT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] FPT  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] key, pt, held;
    bit stable;
    n_chk = 0; n_err = 0;
    rst_ = 1'b1; transformer_start = 1'b0; output_read = 1'b0; ciphertext = '0;
    for (int r = 0; r < 11; r++) rk_a[r] = '0;
    build_sbox();
    expand_key(FKEY);
    step(); step();
    chk("rst_pt", plaintext, 0);
    chk("rst_done", transformer_done, 0);
    chk("rst_busy", transformer_busy, 0);
    rst_ = 1'b0;
    step();

    // FIPS-197 vector, then handshake hold for 30 cycles
    run_op(FCT, FPT, 1'b0);
    held = plaintext; stable = 1'b1;
    repeat (30) begin
      step();
      if (!transformer_done || plaintext !== held) stable = 1'b0;
    end
    chk("hold", stable, 1);
    release_out(FPT);

    // output_read in IDLE is ignored
    output_read = 1'b1; step(); output_read = 1'b0; step();
    chk("idle_rd_done", transformer_done, 0);
    chk("idle_rd_busy", transformer_busy, 0);

    // spurious start edge and output_read during ROUND
    run_op(FCT, FPT, 1'b1);
    release_out(FPT);

    // sticky start through DONE and output_read
    run_op(FCT, FPT, 1'b0);
    output_read = 1'b1; step(); output_read = 1'b0;
    chk("sticky_done", transformer_done, 0);
    repeat (5) step();
    chk("sticky_busy", transformer_busy, 0);
    transformer_start = 1'b0; step();
    run_op(FCT, FPT, 1'b0);
    release_out(FPT);

    // reset mid-operation
    ciphertext = FCT; transformer_start = 1'b1; step();
    repeat (LAT / 2 - 1) step();
    rst_ = 1'b1; transformer_start = 1'b0; step();
    chk("mid_rst_done", transformer_done, 0);
    chk("mid_rst_busy", transformer_busy, 0);
    chk("mid_rst_pt", plaintext, 0);
    rst_ = 1'b0; step();
    run_op(FCT, FPT, 1'b0);
    release_out(FPT);

    // round-trip with a fixed block, then random keys/blocks
    key = {$urandom, $urandom, $urandom, $urandom};
    expand_key(key);
    pt = 128'h00041214120412000C00131108231919;
    run_op(encrypt(pt), pt, 1'b0);
    release_out(pt);
    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      run_op(encrypt(pt), pt, 1'b0);
      release_out(pt);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/engine_inv_round_transformer.md
Name: engine_inv_round_transformer

Overview:
Iterative AES-128 decryption datapath: the inverse of engine_round_transformer. Takes a 128-bit ciphertext and the eleven expanded round keys from the key expander. Runs the FIPS-197 inverse cipher, one round per clock, and presents the plaintext to the output interface. It uses the same start/done/output_read handshake as the encryption transformer.

Parameters:
NR, 10, number of AES rounds (fixed for AES-128; other values unsupported).

Ports:
clk  input  1  system clock, rising edge.
rst_  input  1  synchronous, active-high reset.
ciphertext  input  128  block to decrypt; [127:120] = state byte 0 (row0,col0), column-major per FIPS-197.
transformer_start  input  1  level request; an operation begins on its rising edge.
output_read  input  1  output interface has consumed plaintext.
round0_key..round10_key  input  128 each  expanded keys; round10_key is applied first.
plaintext  output  128  decrypted block, registered.
transformer_done  output  1  plaintext valid; held until output_read.
transformer_busy  output  1  high while rounds are executing.

Behaviour:
- Reset (rst_ high at a clk edge): FSM→IDLE, plaintext=0, transformer_done=0, transformer_busy=0, round counter=0, start_q=0. Reset wins over every other input, including mid-operation; a partial result is discarded.
- start_q registers transformer_start every cycle. start_edge = transformer_start & ~start_q.
- start_q resets to 0, so a start already high when reset is released counts as an edge.
- IDLE: on start_edge:
  - state_reg ← ciphertext ^ round10_key; round ← 9; busy ← 1; →ROUND.
  - ciphertext is sampled only at this edge.
- ROUND (rounds 9 down to 1, one clock each):
  - state_reg ← InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ round_key[round]).
  - round decrements each cycle; when round==1 →FINAL.
- FINAL (one clock):
  - plaintext ← InvSubBytes(InvShiftRows(state_reg)) ^ round0_key.
  - done ← 1; busy ← 0; →DONE.
- Latency: done rises 10 clk edges after the edge that samples start_edge; the 11th edge counting the load edge.
- DONE:
  - done and plaintext hold until output_read is sampled high.
  - On that edge: done ← 0, →IDLE. plaintext keeps its value until the next FINAL.
- Re-start:
  - A start held high through DONE does not re-trigger; it must go low and rise again.
  - A start_edge in DONE coincident with output_read is ignored (no new start_edge can exist while start is still high).
- Ignored inputs:
  - output_read outside DONE is ignored.
  - start_edge outside IDLE is ignored; it is not queued.
- Round keys are read combinationally each cycle and must be stable from start_edge until done.
- Inverse S-box is an internal 256×8 combinational ROM, 16 instances.
- InvMixColumns uses GF(2^8) xtime with polynomial 0x11B and multipliers 0e/0b/0d/09.

Optional Feature:
INV_SBOX_PIPE_EN:
- Defined: a pipeline register is inserted after InvSubBytes.
  - Each ROUND and FINAL step takes 2 clocks: sub-phase A registers SubBytes(ShiftRows(state)); sub-phase B applies the key XOR and InvMixColumns.
  - done rises 20 edges after the start-sampling edge.
  - busy stays high throughout; all handshake rules are unchanged.
- Undefined: single-cycle rounds, 10-edge latency as above.

Test Plan:
- FIPS-197 App. B: ciphertext 3925841d02dc09fbdc118597196a0b32, round keys from key 2b7e151628aed2a6abf7158809cf4f3c (round10 d014f9a8c9ee2589e13f0cc8b6630ca6) → plaintext 3243f6a8885a308d313198a2e0370734. done exactly 10 edges after the start edge (20 with INV_SBOX_PIPE_EN).
- Round-trip: encrypt 00041214120412000C00131108231919 with engine_round_transformer under keys 2475A2B3…/…DBF92E26D538D2D2F49B88C00DDB4F40, feed its ciphertext here with the same keys → plaintext 00041214120412000C00131108231919.
- Handshake hold: keep output_read=0 for 30 cycles after done → done stays 1 and plaintext stable. Pulse output_read 1 cycle → done 0 on the next edge, FSM IDLE.
- Sticky start: hold transformer_start=1 through DONE and output_read → no second operation (busy stays 0). Drop start for 1 cycle and raise it again → new decryption completes.
- Reset mid-operation: assert rst_ at round 5 → next edge done=0, busy=0, plaintext=0. A following start_edge decrypts correctly.
- Spurious inputs: pulse output_read in IDLE and a second start_edge during ROUND → no state change, result still equals the FIPS-197 vector.
